// File: rtl/vx_mem_req_initiator.sv
// Block traffic initiator for the VX_mem request/response channel: issues patterned
// line writes or reads and checks read data. Watchdog enabled by VX_MEM_INIT_TIMEOUT_EN.
module vx_mem_req_initiator #(
   parameter int ADDR_WIDTH      = 26,
   parameter int DATA_WIDTH      = 512,
   parameter int TAG_WIDTH       = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_rw_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [15:0]           cmd_count_i,
   input  logic [31:0]           cmd_seed_i,
   output logic                  mem_req_valid_o,
   output logic                  mem_req_rw_o,
   output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
   output logic [TAG_WIDTH-1:0]  mem_req_tag_o,
   output logic [DATA_WIDTH-1:0] mem_req_data_o,
   input  logic                  mem_req_ready_i,
   input  logic                  mem_rsp_valid_i,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
   input  logic [TAG_WIDTH-1:0]  mem_rsp_tag_i,
   output logic                  mem_rsp_ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [15:0]           err_cnt_o,
   output logic [ADDR_WIDTH-1:0] first_err_addr_o,
   output logic                  timeout_o
);

   localparam int LANES = DATA_WIDTH / 32;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic [DATA_WIDTH-1:0] beat_pattern(input logic [31:0] value);
      logic [DATA_WIDTH-1:0] line;
      line = '0;
      for (int i = 0; i < LANES; i++) begin
         line[i*32 +: 32] = value;
      end
      return line;
   endfunction

   state_e                state_q, state_d;
   logic                  rw_q, rw_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [31:0]           seed_q, seed_d;
   logic [15:0]           count_q, count_d;
   logic [15:0]           issued_q, issued_d;
   logic [15:0]           rsp_cnt_q, rsp_cnt_d;
   logic [OUT_W-1:0]      outstanding_q, outstanding_d;
   logic                  req_valid_q, req_valid_d;
   logic                  req_rw_q, req_rw_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [TAG_WIDTH-1:0]  req_tag_q, req_tag_d;
   logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
   logic                  rsp_ready_q, rsp_ready_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [15:0]           err_cnt_q, err_cnt_d;
   logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
   logic                  timeout_q, timeout_d;

   logic                  cmd_fire;
   logic                  req_fire;
   logic                  rsp_fire;
   logic                  rsp_bad;
   logic                  slot_free;
   logic                  more_beats;
   logic                  have_credit;
   logic                  timeout_hit;

`ifdef VX_MEM_INIT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] timer_q, timer_d;
`endif

   // Next-state, beat generation, credit tracking and response checking.
   always_comb begin
      state_d       = state_q;
      rw_d          = rw_q;
      base_d        = base_q;
      seed_d        = seed_q;
      count_d       = count_q;
      issued_d      = issued_q;
      rsp_cnt_d     = rsp_cnt_q;
      outstanding_d = outstanding_q;
      req_valid_d   = req_valid_q;
      req_rw_d      = req_rw_q;
      req_addr_d    = req_addr_q;
      req_tag_d     = req_tag_q;
      req_data_d    = req_data_q;
      err_cnt_d     = err_cnt_q;
      first_err_d   = first_err_q;
      timeout_d     = timeout_q;

      cmd_fire    = cmd_valid_i && (state_q == ST_IDLE);
      req_fire    = req_valid_q && mem_req_ready_i;
      rsp_fire    = rsp_ready_q && mem_rsp_valid_i;
      rsp_bad     = (mem_rsp_data_i != beat_pattern(seed_q + {16'd0, rsp_cnt_q})) ||
                    (mem_rsp_tag_i != TAG_WIDTH'(rsp_cnt_q));
      slot_free   = !req_valid_q || req_fire;
      more_beats  = (issued_q < count_q);
      have_credit = 1'b0;

      case ({req_fire && !rw_q, rsp_fire})
         2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
         2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase

      if (rsp_fire) begin
         rsp_cnt_d = rsp_cnt_q + 16'd1;
         if (rsp_bad) begin
            if (err_cnt_q != 16'hFFFF) begin
               err_cnt_d = err_cnt_q + 16'd1;
            end else begin
               err_cnt_d = err_cnt_q;
            end
            if (err_cnt_q == 16'd0) begin
               first_err_d = base_q + ADDR_WIDTH'(rsp_cnt_q);
            end else begin
               first_err_d = first_err_q;
            end
         end else begin
            err_cnt_d = err_cnt_q;
         end
      end else begin
         rsp_cnt_d = rsp_cnt_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               rw_d          = cmd_rw_i;
               base_d        = cmd_addr_i;
               seed_d        = cmd_seed_i;
               count_d       = cmd_count_i;
               issued_d      = 16'd0;
               rsp_cnt_d     = 16'd0;
               outstanding_d = '0;
               err_cnt_d     = 16'd0;
               first_err_d   = '0;
               timeout_d     = 1'b0;
               state_d       = (cmd_count_i == 16'd0) ? ST_DONE : ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // Reads may only be presented while the post-cycle in-flight count leaves room.
            have_credit = rw_q || (outstanding_d < OUT_W'(MAX_OUTSTANDING));
            if (slot_free && more_beats && have_credit) begin
               req_valid_d = 1'b1;
               req_rw_d    = rw_q;
               req_addr_d  = base_q + ADDR_WIDTH'(issued_q);
               req_tag_d   = TAG_WIDTH'(issued_q);
               req_data_d  = beat_pattern(seed_q + {16'd0, issued_q});
               issued_d    = issued_q + 16'd1;
            end else if (req_fire) begin
               req_valid_d = 1'b0;
            end else begin
               req_valid_d = req_valid_q;
            end
            if (req_fire && (issued_q == count_q)) begin
               state_d = rw_q ? ST_DONE : ST_DRAIN;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (outstanding_d == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef VX_MEM_INIT_TIMEOUT_EN
      timer_d     = timer_q;
      timeout_hit = 1'b0;
      if (cmd_fire) begin
         timer_d = '0;
      end else if ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) begin
         if (rsp_fire) begin
            timer_d = '0;
         end else if (outstanding_q != '0) begin
            timer_d     = timer_q + TO_W'(1);
            timeout_hit = (timer_q == TO_W'(TIMEOUT_CYCLES - 1));
         end else begin
            timer_d = timer_q;
         end
      end else begin
         timer_d = timer_q;
      end
`else
      timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

      if (timeout_hit) begin
         timeout_d   = 1'b1;
         req_valid_d = 1'b0;
         state_d     = ST_DONE;
      end else begin
         timeout_d = timeout_d;
      end

      rsp_ready_d = ((state_d == ST_ISSUE) || (state_d == ST_DRAIN)) && !rw_d &&
                    (outstanding_d != '0);
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q       <= ST_IDLE;
         rw_q          <= 1'b0;
         base_q        <= '0;
         seed_q        <= 32'd0;
         count_q       <= 16'd0;
         issued_q      <= 16'd0;
         rsp_cnt_q     <= 16'd0;
         outstanding_q <= '0;
         req_valid_q   <= 1'b0;
         req_rw_q      <= 1'b0;
         req_addr_q    <= '0;
         req_tag_q     <= '0;
         req_data_q    <= '0;
         rsp_ready_q   <= 1'b0;
         cmd_ready_q   <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_cnt_q     <= 16'd0;
         first_err_q   <= '0;
         timeout_q     <= 1'b0;
`ifdef VX_MEM_INIT_TIMEOUT_EN
         timer_q       <= '0;
`endif
      end else begin
         state_q       <= state_d;
         rw_q          <= rw_d;
         base_q        <= base_d;
         seed_q        <= seed_d;
         count_q       <= count_d;
         issued_q      <= issued_d;
         rsp_cnt_q     <= rsp_cnt_d;
         outstanding_q <= outstanding_d;
         req_valid_q   <= req_valid_d;
         req_rw_q      <= req_rw_d;
         req_addr_q    <= req_addr_d;
         req_tag_q     <= req_tag_d;
         req_data_q    <= req_data_d;
         rsp_ready_q   <= rsp_ready_d;
         cmd_ready_q   <= cmd_ready_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_cnt_q     <= err_cnt_d;
         first_err_q   <= first_err_d;
         timeout_q     <= timeout_d;
`ifdef VX_MEM_INIT_TIMEOUT_EN
         timer_q       <= timer_d;
`endif
      end
   end

   assign cmd_ready_o      = cmd_ready_q;
   assign mem_req_valid_o  = req_valid_q;
   assign mem_req_rw_o     = req_rw_q;
   assign mem_req_addr_o   = req_addr_q;
   assign mem_req_tag_o    = req_tag_q;
   assign mem_req_data_o   = req_data_q;
   assign mem_rsp_ready_o  = rsp_ready_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign err_cnt_o        = err_cnt_q;
   assign first_err_addr_o = first_err_q;
   assign timeout_o        = timeout_q;

endmodule
